complement_unit: RTL and testbench

COMPLEMENT_UNIT -- requirements
Module: complement_unit

---
 rtl/complement_pkg.sv | 30 +++
 rtl/complement_stage.sv | 56 +++++
 rtl/complement_unit.sv | 124 ++++++++++++
 tb/tb_complement_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/complement_pkg.sv
// Shared types for complement_unit: operation modes, result flag layout and mode helpers.
// Optional saturation is selected by COMPLEMENT_UNIT_SAT_EN in complement_unit.sv.
package complement_pkg;

    typedef enum logic [1:0] {
        NOT  = 2'd0,
        NEG  = 2'd1,
        ABS  = 2'd2,
        PASS = 2'd3
    } op_mode_t;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_W     = 3;

    typedef logic [FLAG_W-1:0] flags_t;

    // Modes that go through the ~a + 1 adder and can therefore overflow
    function automatic logic is_arith(input op_mode_t mode);
        logic res;
        case (mode)
            NEG:     res = 1'b1;
            ABS:     res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/complement_stage.sv
// One-entry valid/ready pipeline register; accepts when empty or when its
// entry drains on the same edge, so a chain of these runs at full rate.
module complement_stage #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             load_s;
    logic             drain_s;

    // Ready is forced low while reset is held so nothing is accepted mid-reset
    assign in_ready  = rst_n & (~valid_q | out_ready);
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Next-state for occupancy and payload; payload only moves on a load
    always_comb begin
        load_s  = in_valid & in_ready;
        drain_s = valid_q & out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (load_s) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (drain_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/complement_unit.sv
// Two-stage NOT/NEG/ABS/PASS unit with valid/ready handshakes and status flags.
// Define COMPLEMENT_UNIT_SAT_EN to saturate overflowing NEG/ABS results.
module complement_unit
    import complement_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_RESULT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_flags
);

    localparam int S1_W = WIDTH + 2;
    localparam int S2_W = WIDTH + FLAG_W;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [S2_W-1:0]  S2_RESET = {{FLAG_W{1'b0}}, RESET_RESULT};

    logic            s1_valid_s;
    logic            s1_ready_s;
    logic [S1_W-1:0] s1_data_s;
    logic            s2_ready_s;
    logic [S2_W-1:0] s2_in_data_s;
    logic [S2_W-1:0] s2_data_s;

    logic [WIDTH-1:0] a_s;
    op_mode_t         mode_s;
    logic [WIDTH:0]   neg_sum_s;
    logic [WIDTH-1:0] result_s;
    logic             ovf_s;
    flags_t           flags_s;

    complement_stage #(
        .WIDTH     (S1_W),
        .RESET_VAL ({S1_W{1'b0}})
    ) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (s1_ready_s),
        .in_data   ({in_mode, in_data}),
        .out_valid (s1_valid_s),
        .out_ready (s2_ready_s),
        .out_data  (s1_data_s)
    );

    assign in_ready = s1_ready_s;

    // Operation datapath between the stages; carry is the ~a + 1 carry-out
    always_comb begin
        a_s       = s1_data_s[WIDTH-1:0];
        mode_s    = op_mode_t'(s1_data_s[WIDTH+1:WIDTH]);
        neg_sum_s = {1'b0, ~a_s} + {{WIDTH{1'b0}}, 1'b1};
        ovf_s     = is_arith(mode_s) & (a_s == MIN_NEG);
        result_s  = a_s;
        flags_s   = '0;
        case (mode_s)
            NOT: begin
                result_s = ~a_s;
            end
            NEG: begin
                result_s            = neg_sum_s[WIDTH-1:0];
                flags_s[FLAG_CARRY] = neg_sum_s[WIDTH];
            end
            ABS: begin
                if (a_s[WIDTH-1]) begin
                    result_s = neg_sum_s[WIDTH-1:0];
                end else begin
                    result_s = a_s;
                end
                flags_s[FLAG_CARRY] = neg_sum_s[WIDTH];
            end
            PASS: begin
                result_s = a_s;
            end
            default: begin
                result_s = a_s;
            end
        endcase
`ifdef COMPLEMENT_UNIT_SAT_EN
        if (ovf_s) begin
            result_s = MAX_POS;
        end else begin
            result_s = result_s;
        end
`else
        // Two's-complement wrap already leaves the most negative value unchanged
        if (ovf_s) begin
            result_s = MIN_NEG;
        end else begin
            result_s = result_s;
        end
`endif
        flags_s[FLAG_OVF]  = ovf_s;
        flags_s[FLAG_ZERO] = (result_s == {WIDTH{1'b0}});
        s2_in_data_s       = {flags_s, result_s};
    end

    complement_stage #(
        .WIDTH     (S2_W),
        .RESET_VAL (S2_RESET)
    ) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid_s),
        .in_ready  (s2_ready_s),
        .in_data   (s2_in_data_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data_s)
    );

    assign out_data  = s2_data_s[WIDTH-1:0];
    assign out_flags = s2_data_s[S2_W-1:WIDTH];

endmodule

// File: tb/tb_complement_unit.sv
// Self-checking bench for complement_unit (WIDTH=8) against a behavioural model.
module tb_complement_unit;

    localparam logic [7:0] RST_VAL = 8'h3C;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_flags;

    int total;
    int bad;

    complement_unit #(.WIDTH(8), .RESET_RESULT(RST_VAL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {ovf, carry, zero, result[7:0]} from plain integer arithmetic
    function automatic logic [10:0] model(input int mode, input int a);
        int r;
        int c;
        int o;
        int negv;
        negv = (256 - a) % 256;
        c    = 0;
        o    = 0;
        r    = a;
        if (mode == 0) r = 255 - a;
        if (mode == 1 || mode == 2) begin
            c = (a == 0) ? 1 : 0;
            o = (a == 128) ? 1 : 0;
            r = (mode == 1 || a >= 128) ? negv : a;
        end
`ifdef COMPLEMENT_UNIT_SAT_EN
        if (o == 1) r = 127;
`endif
        return {o[0], c[0], (r == 0), r[7:0]};
    endfunction

    task automatic run_op(input logic [1:0] m, input logic [7:0] a,
                          output logic [7:0] d, output logic [2:0] f, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_mode   = m;
        in_data   = a;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        d   = 8'h00;
        f   = 3'b000;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (out_valid && lat < 0) begin
                lat = k + 1;
                d   = out_data;
                f   = out_flags;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; in_mode = 2'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_data !== RST_VAL || out_flags !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b d=%h f=%b want v=0 d=%h f=000",
                     out_valid, out_data, out_flags, RST_VAL);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] d;
        logic [2:0] f;
        int lat;
        logic [1:0]  modes [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
        logic [7:0]  ins   [6] = '{8'h5A, 8'h01, 8'h00, 8'h80, 8'h80, 8'hFB};
`ifdef COMPLEMENT_UNIT_SAT_EN
        logic [10:0] exps  [6] = '{{3'b000, 8'hA5}, {3'b000, 8'hFF}, {3'b011, 8'h00},
                                   {3'b100, 8'h7F}, {3'b100, 8'h7F}, {3'b000, 8'h05}};
`else
        logic [10:0] exps  [6] = '{{3'b000, 8'hA5}, {3'b000, 8'hFF}, {3'b011, 8'h00},
                                   {3'b100, 8'h80}, {3'b100, 8'h80}, {3'b000, 8'h05}};
`endif
        for (int i = 0; i < 6; i++) begin
            run_op(modes[i], ins[i], d, f, lat);
            total++;
            if (lat !== 2) begin
                bad++;
                $display("FAIL latency[%0d]: got %0d want 2", i, lat);
            end
            total++;
            if ({f, d} !== exps[i]) begin
                bad++;
                $display("FAIL vector[%0d] mode=%0d a=%h: got f=%b d=%h want f=%b d=%h",
                         i, modes[i], ins[i], f, d, exps[i][10:8], exps[i][7:0]);
            end
        end
    endtask

    task automatic test_stall();
        int accepts;
        int sent;
        logic [7:0] vals [3] = '{8'h10, 8'h11, 8'h12};
        accepts = 0;
        sent    = 0;
        out_ready = 1'b0;
        in_mode   = 2'd3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = (sent < 3);
            in_data  = vals[(sent < 3) ? sent : 2];
            #1;
            if (in_valid && in_ready) begin
                accepts++;
                sent++;
            end
        end
        total++;
        if (accepts !== 2 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_fill: got accepts=%0d in_ready=%b want 2 and 0", accepts, in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (sent < 3);
            in_data   = vals[(sent < 3) ? sent : 2];
            #1;
            if (in_valid && in_ready) sent++;
            total++;
            if (out_valid !== 1'b1 || out_data !== vals[c]) begin
                bad++;
                $display("FAIL stall_drain[%0d]: got v=%b d=%h want v=1 d=%h",
                         c, out_valid, out_data, vals[c]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_extra: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        in_mode   = 2'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h20 + 8'(c);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL midflight_full: got v=%b rdy=%b want 1 0", out_valid, in_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== RST_VAL || out_flags !== 3'b000 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL midflight_reset: got v=%b d=%h f=%b rdy=%b want 0 %h 000 0",
                     out_valid, out_data, out_flags, in_ready, RST_VAL);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL midflight_stale[%0d]: got out_valid=%b want 0", c, out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] exp_q [$];
        logic [10:0] e;
        logic        stalled;
        logic [7:0]  prev_d;
        logic [2:0]  prev_f;
        int          occ;
        int          m;
        int          a;
        stalled = 1'b0;
        prev_d  = 8'h00;
        prev_f  = 3'b000;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            m = $urandom_range(0, 3);
            a = $urandom_range(0, 255);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_mode   = m[1:0];
            in_data   = a[7:0];
            #1;
            occ = exp_q.size();
            total++;
            if (in_ready !== ((occ < 2) || out_ready)) begin
                bad++;
                $display("FAIL rand_in_ready cyc=%0d: got %b occ=%0d out_ready=%b", c, in_ready, occ, out_ready);
            end
            if (stalled) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_flags !== prev_f) begin
                    bad++;
                    $display("FAIL rand_hold cyc=%0d: got v=%b d=%h f=%b want 1 %h %b",
                             c, out_valid, out_data, out_flags, prev_d, prev_f);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_spurious cyc=%0d: got d=%h want no result", c, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_flags, out_data} !== e) begin
                        bad++;
                        $display("FAIL rand_result cyc=%0d: got f=%b d=%h want f=%b d=%h",
                                 c, out_flags, out_data, e[10:8], e[7:0]);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(m, a));
            stalled = out_valid && !out_ready;
            prev_d  = out_data;
            prev_f  = out_flags;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({out_flags, out_data} !== e) begin
                    bad++;
                    $display("FAIL rand_drain: got f=%b d=%h want f=%b d=%h",
                             out_flags, out_data, e[10:8], e[7:0]);
                end
            end
            @(negedge clk);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rand_dropped: got %0d results missing want 0", exp_q.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_vectors();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
